// File: rtl/rf_sched_pkg.sv
// Shared widths and the writeback request record used by the RF write-port
// scheduler and its source-B skid FIFO.
package rf_sched_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wa;
        logic [DATA_W-1:0]     wd;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous skid FIFO for source-B writeback requests; head is
// presented combinationally so the arbiter can pop it in the same cycle.
module rf_wb_fifo
    import rf_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single RF write port between the fixed-latency WB stage (A)
// and the long-latency unit (B), with starvation relief and a B scoreboard.
module rf_wb_scheduler
    import rf_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rk,
    input  logic [REG_ADDR_W-1:0] issue_rj,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_use_k,
    input  logic                  issue_use_j,
    input  logic                  issue_use_d,
    input  logic                  issue_wen,
    input  logic                  issue_long,
    output logic                  issue_stall,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_wa,
    input  logic [DATA_W-1:0]     a_wd,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_wa,
    input  logic [DATA_W-1:0]     b_wd,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0]     rf_wd,
    output logic                  pipe_hold,
    output logic [NUM_REGS-1:0]   sb_pending
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    wb_req_t             push_req;
    wb_req_t             head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                b_push;
    logic                b_pop;
    logic                a_win;
    logic                starve_inc;
    logic                hold_set;
    logic [CNT_W-1:0]    starve_cnt;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [NUM_REGS-1:0] sb_set;
    logic [NUM_REGS-1:0] sb_clr;
    logic                issue_accept;

    assign push_req = '{wa: b_wa, wd: b_wd};
    assign b_ready  = !rst && !fifo_full;
    assign b_push   = b_valid && b_ready;
    assign a_win    = !rst && a_valid && !pipe_hold;
    assign b_pop    = !rst && !a_win && !fifo_empty;

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_data (push_req),
        .pop       (b_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (a_win) begin
            rf_we = 1'b1;
            rf_wa = a_wa;
            rf_wd = a_wd;
        end else if (b_pop) begin
            rf_we = 1'b1;
            rf_wa = head.wa;
            rf_wd = head.wd;
        end
    end

    // pipe_hold self-clears: while it is high A cannot win, so no increment
    assign starve_inc = a_win && !fifo_empty;
    assign hold_set   = starve_inc && (starve_cnt == CNT_W'(STARVE_MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            pipe_hold  <= 1'b0;
        end else begin
            pipe_hold <= hold_set;
            if (b_pop || fifo_empty) starve_cnt <= '0;
            else if (starve_inc)     starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Registered bitmap only: a same-cycle clear still stalls for one cycle
    assign issue_stall = issue_valid && ((issue_use_k && pending[issue_rk]) ||
                                         (issue_use_j && pending[issue_rj]) ||
                                         (issue_use_d && pending[issue_rd]) ||
                                         (issue_wen   && pending[issue_rd]));
    assign issue_accept = issue_valid && !issue_stall;

    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (issue_accept && issue_wen && issue_long && (issue_rd != '0))
            sb_set[issue_rd] = 1'b1;
        if (b_pop && (head.wa != '0))
            sb_clr[head.wa] = 1'b1;
        pending_nxt    = (pending & ~sb_clr) | sb_set;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    assign sb_pending = pending;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(a_valid && pipe_hold))
                else $error("a_valid raised while pipe_hold high; source A write dropped");
            assert ((sb_set & sb_clr) == '0)
                else $error("scoreboard set and clear on the same register");
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed and randomized checks of rf_wb_scheduler against a queue-based
// reference model of the write-port, starvation and scoreboard rules.
module tb_rf_wb_scheduler;
    import rf_sched_pkg::*;

    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid, issue_use_k, issue_use_j, issue_use_d, issue_wen, issue_long;
    logic [4:0]  issue_rk, issue_rj, issue_rd;
    logic        issue_stall;
    logic        a_valid, b_valid, b_ready, rf_we, pipe_hold;
    logic [4:0]  a_wa, b_wa, rf_wa;
    logic [31:0] a_wd, b_wd, rf_wd, sb_pending;

    rf_wb_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rk(issue_rk), .issue_rj(issue_rj), .issue_rd(issue_rd),
        .issue_use_k(issue_use_k), .issue_use_j(issue_use_j), .issue_use_d(issue_use_d),
        .issue_wen(issue_wen), .issue_long(issue_long), .issue_stall(issue_stall),
        .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pipe_hold(pipe_hold), .sb_pending(sb_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wb_req_t     mq[$];
    logic [4:0]  owed[$];
    logic [31:0] m_pend;
    int          m_cnt;
    bit          m_hold;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        owed.delete();
        m_pend = '0;
        m_cnt  = 0;
        m_hold = 1'b0;
    endtask

    function automatic bit exp_stall();
        return issue_valid && ((issue_use_k && m_pend[issue_rk]) ||
                               (issue_use_j && m_pend[issue_rj]) ||
                               (issue_use_d && m_pend[issue_rd]) ||
                               (issue_wen   && m_pend[issue_rd]));
    endfunction

    task automatic compare_all(string tag);
        bit          a_win, pop;
        logic [4:0]  wa;
        logic [31:0] wd;
        a_win = a_valid && !m_hold;
        pop   = !a_win && (mq.size() != 0);
        wa    = a_win ? a_wa : (pop ? mq[0].wa : 5'd0);
        wd    = a_win ? a_wd : (pop ? mq[0].wd : 32'd0);
        check({tag, ".rf_we"},   rf_we, a_win || pop);
        check({tag, ".rf_wa"},   rf_wa, wa);
        check({tag, ".rf_wd"},   rf_wd, wd);
        check({tag, ".b_ready"}, b_ready, mq.size() < FIFO_DEPTH);
        check({tag, ".stall"},   issue_stall, exp_stall());
        check({tag, ".hold"},    pipe_hold, m_hold);
        check({tag, ".pending"}, sb_pending, m_pend);
    endtask

    task automatic model_step();
        bit      a_win, was_empty, pop, accept, push_ok, new_hold;
        wb_req_t h;
        a_win     = a_valid && !m_hold;
        was_empty = (mq.size() == 0);
        pop       = !a_win && !was_empty;
        accept    = issue_valid && !exp_stall();
        push_ok   = b_valid && (mq.size() < FIFO_DEPTH);
        new_hold  = !was_empty && a_win && (m_cnt == STARVE_MAX - 1);
        if (pop || was_empty) m_cnt = 0;
        else if (a_win)       m_cnt = m_cnt + 1;
        if (pop) begin
            h = mq.pop_front();
            if (h.wa != 5'd0) m_pend[h.wa] = 1'b0;
        end
        if (accept && issue_wen && issue_long) begin
            owed.push_back(issue_rd);
            if (issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
        end
        if (push_ok) begin
            mq.push_back({b_wa, b_wd});
            if (owed.size() != 0) void'(owed.pop_front());
        end
        m_hold = new_hold;
    endtask

    task automatic cycle(string tag);
        @(negedge clk);
        compare_all(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_use_k = 0; issue_use_j = 0; issue_use_d = 0;
        issue_wen = 0; issue_long = 0; issue_rk = 0; issue_rj = 0; issue_rd = 0;
        a_valid = 0; a_wa = 0; a_wd = 0; b_valid = 0; b_wa = 0; b_wd = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        a_valid = 1; a_wa = 5'd4; a_wd = 32'h55;
        issue_valid = 1; issue_use_k = 1; issue_rk = 5'd5;
        #3;
        check("rst_rf_we", rf_we, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_stall", issue_stall, 0);
        check("rst_hold", pipe_hold, 0);
        check("rst_pending", sb_pending, 0);
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();

        // A write in the same cycle
        a_valid = 1; a_wa = 5'd3; a_wd = 32'h11;
        #1;
        check("a_wr_we", rf_we, 1);
        check("a_wr_wa", rf_wa, 3);
        check("a_wr_wd", rf_wd, 32'h11);
        check("a_wr_b_ready", b_ready, 1);
        cycle("a_wr");

        // RAW stall on a long destination
        idle_inputs();
        issue_valid = 1; issue_wen = 1; issue_long = 1; issue_rd = 5'd5;
        cycle("iss_long5");
        idle_inputs();
        issue_valid = 1; issue_use_j = 1; issue_rj = 5'd5; issue_rd = 5'd6; issue_wen = 1;
        #1;
        check("raw_stall", issue_stall, 1);
        check("raw_pending", sb_pending, 32'h20);
        cycle("raw");
        b_valid = 1; b_wa = 5'd5; b_wd = 32'hAB;
        cycle("b5_push");
        b_valid = 0;
        #1;
        check("b5_pop_wa", rf_wa, 5);
        check("b5_pop_wd", rf_wd, 32'hAB);
        check("b5_pop_still_stall", issue_stall, 1);
        cycle("b5_pop");
        #1;
        check("b5_stall_drop", issue_stall, 0);
        cycle("b5_after");

        // Starvation: A valid every cycle while B fills the FIFO
        idle_inputs();
        a_valid = 1; a_wa = 5'd1; a_wd = $urandom;
        b_valid = 1; b_wa = 5'd7; b_wd = 32'h77;
        cycle("starve_push7");
        a_wa = 5'd2; a_wd = $urandom;
        b_wa = 5'd8; b_wd = 32'h88;
        cycle("starve_push8");
        b_valid = 0;
        for (int c = 2; c <= 6; c++) begin
            a_valid = !m_hold; a_wa = 5'(c); a_wd = $urandom;
            #1;
            check("starve_hold", pipe_hold, c == 5);
            if (c == 2) check("starve_full", b_ready, 0);
            if (c == 5) check("starve_pop7", rf_wa, 7);
            if (c == 6) check("starve_a_wins", rf_wa, 6);
            cycle("starve");
        end
        a_valid = 0;
        #1;
        check("starve_pop8_wa", rf_wa, 8);
        check("starve_pop8_wd", rf_wd, 32'h88);
        cycle("starve_pop8");

        // Long write to r0 never tracked
        idle_inputs();
        issue_valid = 1; issue_wen = 1; issue_long = 1; issue_rd = 5'd0;
        cycle("iss_long0");
        issue_long = 0; issue_wen = 0;
        issue_use_k = 1; issue_use_j = 1; issue_use_d = 1;
        #1;
        check("r0_no_stall", issue_stall, 0);
        check("r0_bit", sb_pending[0], 0);
        cycle("r0_use");
        idle_inputs();
        b_valid = 1; b_wa = 5'd0; b_wd = 32'h99;
        cycle("b0_push");
        b_valid = 0;
        cycle("b0_pop");

        // Reset in the middle of traffic
        issue_valid = 1; issue_wen = 1; issue_long = 1; issue_rd = 5'd5;
        cycle("iss_long5b");
        idle_inputs();
        a_valid = 1; a_wa = 5'd10; a_wd = $urandom;
        b_valid = 1; b_wa = 5'd5; b_wd = 32'h5;
        cycle("mid_push1");
        b_wa = 5'd9; b_wd = 32'h9;
        cycle("mid_push2");
        b_valid = 0;
        #1;
        check("mid_pending", sb_pending, 32'h20);
        check("mid_full", b_ready, 0);
        rst = 1;
        #1;
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_b_ready", b_ready, 0);
        check("mid_rst_pending", sb_pending, 0);
        check("mid_rst_hold", pipe_hold, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        #1;
        check("post_rst_empty_we", rf_we, 0);
        check("post_rst_b_ready", b_ready, 1);
        cycle("post_rst");

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            a_valid     = m_hold ? 1'b0 : ($urandom_range(0, 99) < 55);
            a_wa        = 5'($urandom);
            a_wd        = $urandom;
            b_valid     = (owed.size() != 0) && ($urandom_range(0, 99) < 60);
            b_wa        = (owed.size() != 0) ? owed[0] : 5'd0;
            b_wd        = $urandom;
            issue_valid = $urandom_range(0, 1);
            issue_rk    = 5'($urandom_range(0, 7));
            issue_rj    = 5'($urandom_range(0, 7));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_use_k = $urandom_range(0, 1);
            issue_use_j = $urandom_range(0, 1);
            issue_use_d = $urandom_range(0, 1);
            issue_wen   = $urandom_range(0, 1);
            issue_long  = issue_wen && ($urandom_range(0, 1) == 1);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
